// File: rtl/servo_frame_sequencer_pkg.sv
// servo_frame_sequencer_pkg: shared frame constants and receiver state encoding
package servo_frame_sequencer_pkg;
  localparam logic [7:0] START_BYTE = 8'hFF;
  localparam logic [7:0] SERVO_DEFAULT_POS = 8'd127;
  typedef enum logic [2:0] {IDLE, COUNT, DATA, CSUM, COMMIT} state_t;
endpackage

// File: rtl/servo_frame_sequencer_sat_timer.sv
// sat_timer: saturating up-counter that flags when LIMIT cycles have elapsed
module sat_timer #(
  parameter int LIMIT = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i && cnt_q != W'(LIMIT)) cnt_q <= cnt_q + W'(1);
  assign expired_o = cnt_q == W'(LIMIT);
endmodule

// File: rtl/servo_frame_sequencer.sv
// servo_frame_sequencer: assembles checksummed position frames and commits them to pos_buffer
module servo_frame_sequencer
  import servo_frame_sequencer_pkg::*;
#(
  parameter int NUM_SERVOS      = 1,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int WATCHDOG_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  output logic                    in_ready,
  output logic [8*NUM_SERVOS-1:0] pos_buffer,
  output logic                    trigger,
  output logic                    failsafe,
  output logic                    frame_err,
  output logic [7:0]              err_count
);
  localparam int IW = $clog2(NUM_SERVOS + 1);
  state_t state_q, state_d;
  logic [NUM_SERVOS-1:0][7:0] pos_q, stage_q;
  logic [IW-1:0] n_q, idx_q;
  logic [7:0] acc_q, err_q;
  logic trig_q, ferr_q, seen_q;
  logic accept, in_frame, is_start, last, gap_exp, wd_exp, err, commit;
  assign in_ready = state_q != COMMIT;
  assign accept = in_valid && in_ready;
  assign in_frame = state_q inside {COUNT, DATA, CSUM};
  assign is_start = in_data == START_BYTE;
  assign last = (idx_q + IW'(1)) == n_q;
  always_comb begin
    state_d = state_q;
    err = 1'b0;
    commit = 1'b0;
    case (state_q)
      IDLE: if (accept && is_start) state_d = COUNT;
      COUNT:
        if (accept && !is_start) begin
          err = in_data == 8'd0 || in_data > 8'(NUM_SERVOS);
          state_d = err ? IDLE : DATA;
        end
      DATA: if (accept) state_d = is_start ? COUNT : (last ? CSUM : DATA);
      CSUM:
        if (accept) begin
          commit = in_data == acc_q;
          err = !commit;
          state_d = commit ? COMMIT : IDLE;
        end
      default: state_d = IDLE;
    endcase
    // an accepted byte always beats a gap expiry in the same cycle
    if (in_frame && gap_exp && !accept) begin
      err = 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      pos_q <= {NUM_SERVOS{SERVO_DEFAULT_POS}};
      stage_q <= '0;
      n_q <= '0;
      idx_q <= '0;
      acc_q <= '0;
      err_q <= '0;
      trig_q <= 1'b0;
      ferr_q <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      trig_q <= commit;
      ferr_q <= err;
      if (err && err_q != 8'hFF) err_q <= err_q + 8'd1;
      if (commit) seen_q <= 1'b1;
      if (accept && state_q == COUNT && state_d == DATA) begin
        n_q <= in_data[IW-1:0];
        acc_q <= in_data;
        idx_q <= '0;
      end
      if (accept && state_q == DATA && !is_start) begin
        for (int i = 0; i < NUM_SERVOS; i++)
          if (idx_q == IW'(i)) stage_q[i] <= in_data;
        acc_q <= acc_q + in_data;
        idx_q <= idx_q + IW'(1);
      end
      // only the channels carried by this frame are refreshed
      if (commit)
        for (int i = 0; i < NUM_SERVOS; i++)
          if (IW'(i) < n_q) pos_q[i] <= stage_q[i];
    end
  sat_timer #(.LIMIT(TIMEOUT_CYCLES)) u_gap (
    .clk(clk), .rst_n(rst_n), .clr_i(accept || !in_frame), .en_i(1'b1), .expired_o(gap_exp)
  );
  sat_timer #(.LIMIT(WATCHDOG_CYCLES)) u_wd (
    .clk(clk), .rst_n(rst_n), .clr_i(commit), .en_i(1'b1), .expired_o(wd_exp)
  );
  assign pos_buffer = pos_q;
  assign trigger = trig_q;
  assign frame_err = ferr_q;
  assign err_count = err_q;
  assign failsafe = wd_exp || !seen_q;
endmodule

// File: tb/tb_servo_frame_sequencer.sv
// tb_servo_frame_sequencer: directed and random frames checked against a frame-level model
module tb_servo_frame_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, trigger, failsafe, frame_err;
  logic [31:0] pos_buffer;
  logic [7:0] err_count;
  int checks = 0, errors = 0, trig_n = 0, ferr_n = 0;
  logic [31:0] exp_pos;
  logic [7:0] exp_err;
  logic [7:0] frm[$];

  servo_frame_sequencer #(.NUM_SERVOS(4), .TIMEOUT_CYCLES(10), .WATCHDOG_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .pos_buffer(pos_buffer), .trigger(trigger), .failsafe(failsafe),
    .frame_err(frame_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n) begin
      trig_n += int'(trigger);
      ferr_n += int'(frame_err);
      chk("in_ready_vs_commit", in_ready, !trigger);
    end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    for (int k = 0; k < 8 && !ok; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = b;
      ok = in_ready;
    end
    if (!ok) chk("send_ready", 0, 1);
  endtask

  task automatic send_frm(input int gap);
    foreach (frm[k]) begin
      if (k > 0) idle(gap);
      send_byte(frm[k]);
    end
  endtask

  // frame-level reference: valid count and matching sum commits, anything else is one error
  task automatic model_frame(output bit good);
    int n;
    logic [7:0] s;
    n = int'(frm[1]);
    good = 0;
    if (n >= 1 && n <= 4) begin
      s = frm[1];
      for (int i = 0; i < n; i++) s += frm[2+i];
      good = frm[n+2] == s;
    end
    if (good) for (int i = 0; i < n; i++) exp_pos[8*i +: 8] = frm[2+i];
    else if (exp_err != 8'hFF) exp_err++;
  endtask

  task automatic finish_frame(input bit good);
    @(negedge clk);
    in_valid = 1'b0;
    chk("trigger", trigger, good);
    chk("frame_err", frame_err, !good);
    chk("pos_buffer", pos_buffer, exp_pos);
    chk("err_count", err_count, exp_err);
    if (good) begin
      chk("in_ready_commit", in_ready, 0);
      chk("failsafe_commit", failsafe, 0);
    end
  endtask

  task automatic load(input logic [7:0] a[]);
    frm.delete();
    foreach (a[i]) frm.push_back(a[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit");
    $fatal(1, "time limit");
  end

  initial begin
    bit g;
    int n, tn, fn;
    logic [7:0] s;
    exp_pos = 32'h7F7F7F7F;
    exp_err = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_pos", pos_buffer, 32'h7F7F7F7F);
    chk("rst_failsafe", failsafe, 1);
    chk("rst_err_count", err_count, 0);
    chk("rst_trigger", trigger, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    idle(2);
    chk("pre_commit_failsafe", failsafe, 1);

    load('{8'hFF, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA4});
    send_frm(0); model_frame(g); finish_frame(g);
    chk("f1_pos", pos_buffer, 32'h40302010);
    @(negedge clk);
    chk("f1_trigger_one_cycle", trigger, 0);
    chk("f1_in_ready_back", in_ready, 1);

    load('{8'hFF, 8'h02, 8'h55, 8'h66, 8'hBD});
    send_frm(0); model_frame(g); finish_frame(g);
    chk("f2_pos", pos_buffer, 32'h40306655);

    load('{8'hFF, 8'h02, 8'h55, 8'h66, 8'h00});
    send_frm(0); model_frame(g); finish_frame(g);
    chk("f3_err_count", err_count, 1);

    load('{8'hFF, 8'h03, 8'h11});
    send_frm(0);
    idle(11);
    chk("timeout_early", frame_err, 0);
    idle(1);
    exp_err++;
    chk("timeout_err", frame_err, 1);
    chk("timeout_err_count", err_count, exp_err);
    load('{8'hFF, 8'h01, 8'h22, 8'h23});
    send_frm(0); model_frame(g); finish_frame(g);
    chk("after_timeout_pos", pos_buffer, 32'h40306622);

    fn = ferr_n;
    load('{8'hFF, 8'h03, 8'h11});
    send_frm(0);
    idle(10);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
    exp_pos = 32'h40332211;
    finish_frame(1);
    chk("byte_beats_timeout", ferr_n - fn, 0);

    fn = ferr_n;
    load('{8'hFF, 8'h02, 8'h11, 8'hFF, 8'h01, 8'h33, 8'h34});
    send_frm(0);
    exp_pos[7:0] = 8'h33;
    finish_frame(1);
    chk("restart_no_err", ferr_n - fn, 0);

    load('{8'hFF, 8'h05}); send_frm(0); model_frame(g); finish_frame(g);
    load('{8'hFF, 8'h00}); send_frm(1); model_frame(g); finish_frame(g);

    for (int r = 0; r < 40; r++) begin
      n = $urandom_range(0, 5);
      frm.delete();
      frm.push_back(8'hFF);
      frm.push_back(8'(n));
      if (n >= 1 && n <= 4) begin
        s = 8'(n);
        for (int i = 0; i < n; i++) begin
          frm.push_back(8'($urandom_range(0, 254)));
          s += frm[2+i];
        end
        if ($urandom_range(0, 3) == 0) s ^= 8'($urandom_range(1, 255));
        frm.push_back(s);
      end
      send_frm($urandom_range(0, 3));
      model_frame(g);
      finish_frame(g);
      idle($urandom_range(0, 2));
    end

    load('{8'hFF, 8'h01, 8'h44, 8'h45});
    send_frm(0); model_frame(g); finish_frame(g);
    idle(99);
    chk("watchdog_not_yet", failsafe, 0);
    idle(1);
    chk("watchdog_expired", failsafe, 1);
    load('{8'hFF, 8'h01, 8'h55, 8'h56});
    send_frm(0); model_frame(g); finish_frame(g);

    for (int r = 0; r < 300; r++) begin
      load('{8'hFF, 8'h05});
      send_frm(0); model_frame(g); finish_frame(g);
    end
    chk("err_saturated", err_count, 255);

    load('{8'hFF, 8'h04, 8'h10, 8'h20});
    send_frm(0);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midrst_pos", pos_buffer, 32'h7F7F7F7F);
    chk("midrst_failsafe", failsafe, 1);
    chk("midrst_err_count", err_count, 0);
    chk("midrst_trigger", trigger, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tn = trig_n;
    load('{8'h30, 8'h40, 8'hA4});
    send_frm(0);
    idle(3);
    chk("midrst_no_trigger", trig_n - tn, 0);
    chk("midrst_pos_kept", pos_buffer, 32'h7F7F7F7F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/servo_frame_sequencer.md
Name: servo_frame_sequencer

Overview:
Byte-stream frame receiver and update controller for the servo position latch. It takes position bytes from the AVR link interface, assembles and checksums a frame, then commits the positions into pos_buffer with a one-cycle trigger pulse. It sits between the byte receiver and the output latch. It also drives a failsafe flag, which feeds the latch reset, when updates stop arriving.

Parameters:
NUM_SERVOS, 1, number of servo channels; frame may carry 1..NUM_SERVOS positions
TIMEOUT_CYCLES, 1000, max idle cycles between bytes inside a frame before abort
WATCHDOG_CYCLES, 1000000, cycles without a committed frame before failsafe asserts

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  in_data valid; a byte is accepted when in_valid && in_ready at a rising edge
in_data  in  8  received byte
in_ready  out  1  byte accept enable
pos_buffer  out  8*NUM_SERVOS  committed positions; servo i at bits [8i+7:8i]
trigger  out  1  one-cycle pulse when pos_buffer has just been updated
failsafe  out  1  high when no valid frame committed within WATCHDOG_CYCLES
frame_err  out  1  one-cycle pulse on rejected or aborted frame
err_count  out  8  saturating count of frame errors

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; every pos_buffer byte = 127.
  - trigger=0, frame_err=0, err_count=0, failsafe=1, internal counters=0.
- Frame format: 0xFF start, count N, N position bytes (0..254), checksum.
  - Checksum = (N + sum of positions) mod 256.
- States: IDLE, COUNT, DATA, CSUM, COMMIT. Transitions occur only on accepted bytes, except timeout and COMMIT.
- in_ready = 1 in all states except COMMIT.
- IDLE: 0xFF -> COUNT; any other byte is ignored silently.
- COUNT:
  - 0xFF -> stay in COUNT (restart).
  - N=0 or N>NUM_SERVOS -> error, IDLE.
  - Otherwise latch N, set checksum accumulator = N, index = 0 -> DATA.
- DATA:
  - 0xFF -> restart: go to COUNT with no error.
  - Otherwise write staging[index], add the byte to the accumulator, index++.
  - After the Nth byte -> CSUM.
- CSUM:
  - Any byte value, 0xFF included, is compared against the accumulator.
  - Match -> COMMIT. Mismatch -> error, IDLE.
- Commit timing:
  - On the edge accepting a good checksum, pos_buffer[i] <= staging[i] for i<N only; servos i>=N keep their previous values.
  - trigger is registered 1 on that same edge, so it is high for exactly the COMMIT cycle, with pos_buffer already valid.
  - COMMIT -> IDLE unconditionally after one cycle.
- Error action: frame_err pulses high for 1 cycle; err_count increments and saturates at 255; staging is discarded and pos_buffer is unchanged.
- Timeout:
  - In COUNT/DATA/CSUM, the gap counter clears on every accepted byte and increments otherwise.
  - Reaching TIMEOUT_CYCLES -> error, IDLE.
- Watchdog:
  - The counter clears on commit and increments otherwise, saturating at WATCHDOG_CYCLES.
  - failsafe = 1 when the counter has reached WATCHDOG_CYCLES or no commit has occurred since reset.
  - failsafe clears on the commit edge.
- Simultaneous events:
  - A byte accepted in the same cycle the gap counter would expire: the byte wins, no timeout.
  - Commit and watchdog expiry in the same cycle: commit wins.
- Reset mid-frame: state, staging and counters clear; partial frames are never committed.
- Widths:
  - index and N use $clog2(NUM_SERVOS+1) bits.
  - The accumulator is 8 bits and wraps naturally.
  - Gap and watchdog counters are sized by $clog2 of their parameters.

Decomposition:
- Shared package holds:
  - START_BYTE = 8'hFF
  - SERVO_DEFAULT_POS = 8'd127
  - the state enum (IDLE, COUNT, DATA, CSUM, COMMIT)
- One sub-module is natural: sat_timer (clear, enable, parameter LIMIT, expired flag), instantiated twice: once for the byte gap, once for the watchdog.

Test Plan:
- NUM_SERVOS=4, TIMEOUT_CYCLES=10, WATCHDOG_CYCLES=100 for all scenarios.
- Reset check -> pos_buffer=32'h7F7F7F7F, failsafe=1, err_count=0, trigger=0.
- Send FF 04 10 20 30 40 A4 back-to-back -> trigger high 1 cycle after the A4 edge; pos_buffer=32'h40302010; failsafe=0; in_ready=0 only in that cycle.
- Then send FF 02 55 66 BD -> pos_buffer=32'h40306655; servos 2,3 unchanged.
- Send FF 02 55 66 00 -> frame_err pulse, err_count=1, pos_buffer unchanged, no trigger.
- Send FF 03 11, then in_valid=0 for 10 cycles -> frame_err, err_count increments, IDLE.
  - A following good frame FF 01 22 23 commits servo0=0x22.
- Send FF 02 11 FF 01 33 34 -> first frame dropped with no error; servo0=0x33 committed.
- Send FF 05 -> count error. Separately, 300 garbage frames -> err_count saturates at 255.
- No frames for 100 cycles after a commit -> failsafe=1; the next good frame clears it on the commit edge.
- Assert rst_n low in the middle of a DATA byte sequence -> no trigger, outputs return to their reset values immediately.
